regfile_bank: RTL and testbench
===============================

REGFILE_BANK -- requirements
Module: regfile_bank

Interface
REQ-001 SHALL have parameter OPTION_REG_WIDTH, default 64, data width of every register and data port.
REQ-002 SHALL have parameter OPTION_REG_COUNT, default 32, number of architectural registers; fixed at 32 to match the 5-bit select ports.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  reset, asynchronous, active-low.
REQ-005 i_sela  input  5  read port A register number, driven by the active processing unit.
REQ-006 i_selb  input  5  read port B register number.
REQ-007 o_ina  output  OPTION_REG_WIDTH  read port A data, returned to the processing units.
REQ-008 o_inb  output  OPTION_REG_WIDTH  read port B data.
REQ-009 i_write_reg  input  5  destination register number.
REQ-010 i_write_data  input  OPTION_REG_WIDTH  write data.
REQ-011 i_write_en  input  1  write strobe; the write is latched on the rising edge.
REQ-012 i_clear  input  1  synchronous request to re-zero the whole bank.
REQ-013 o_ready  output  1  1 = bank initialised, writes accepted, reads valid.

Function
REQ-014 SHALL contain a two-state FSM, CLEAR and READY, plus a 5-bit sweep index.
REQ-015 In CLEAR, on each rising edge, the FSM SHALL write zero to register[index] and increment index, starting at 1.
REQ-016 After clearing index 31, the FSM SHALL go to READY, which is exactly 31 cycles after entering CLEAR.
REQ-017 The index SHALL NOT wrap; 31 is terminal.
REQ-018 In READY, i_clear=1 SHALL move the FSM to CLEAR with index=1 on the next edge; the pending write in that cycle SHALL be discarded.
REQ-019 i_clear=1 while already in CLEAR SHALL restart the sweep at index 1.
REQ-020 o_ready SHALL be 1 only in READY (registered state, no combinational path from i_clear).
REQ-021 Register 0 SHALL read as zero at all times, and writes to register 0 SHALL be ignored.
REQ-022 In READY with i_write_en=1 and i_write_reg!=0, register[i_write_reg] SHALL take i_write_data at the rising edge.
REQ-023 i_write_en SHALL be ignored in CLEAR.
REQ-024 Reads SHALL be combinational, with zero-cycle latency from i_sela/i_selb.
REQ-025 In CLEAR, o_ina and o_inb SHALL be forced to zero.
REQ-026 The same select on both ports SHALL return identical data.
REQ-027 Register storage SHALL carry no reset (RAM-inferable); the sweep alone SHALL guarantee zero contents.

Reset
REQ-028 Asserting i_rst low SHALL immediately force state=CLEAR, index=1 and o_ready=0, independent of i_clk.
REQ-029 Reset mid-sweep or mid-write SHALL discard the operation in progress and restart the sweep after deassertion.
REQ-030 During reset, o_ina and o_inb SHALL be zero.

Configuration
REQ-031 Macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-032 With REGFILE_BYPASS_EN defined and in READY, if i_write_en=1 and i_write_reg equals a read select other than 0, that port SHALL output i_write_data in the same cycle.
REQ-033 Without REGFILE_BYPASS_EN, reads SHALL return the stored value; the new value SHALL be visible from the cycle after the write edge.

Verification
REQ-034 Release i_rst -> o_ready=0 for 31 cycles then 1; o_ina=0 for sel=0..31.
REQ-035 Write reg 5 = 0xDEADBEEF_00000001, then sela=5, selb=5 -> both ports read 0xDEADBEEF_00000001 the next cycle.
REQ-036 Write reg 0 = all ones -> sela=0 reads 0.
REQ-037 Write reg 7 = 0x1234 and set sela=7 in the same cycle -> o_ina=0x1234 with REGFILE_BYPASS_EN; without it, o_ina is the old value that cycle and 0x1234 the next.
REQ-038 i_clear pulse with a same-cycle write of reg 3 = 0xFF -> o_ready drops next cycle, 31 cycles later reg 3 reads 0.
REQ-039 Assert i_rst at sweep index 10 -> o_ready=0 immediately; after release the full 31-cycle sweep repeats and reg 20 (written before) reads 0.

Source files
------------

// File: rtl/regfile_bank.sv
// 32-entry register bank with a self-clearing sweep FSM, two combinational read ports and one write port.
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_bank #(
   parameter int unsigned OPTION_REG_WIDTH = 64,
   parameter int unsigned OPTION_REG_COUNT = 32
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic [4:0]                  i_sela,
   input  logic [4:0]                  i_selb,
   output logic [OPTION_REG_WIDTH-1:0] o_ina,
   output logic [OPTION_REG_WIDTH-1:0] o_inb,
   input  logic [4:0]                  i_write_reg,
   input  logic [OPTION_REG_WIDTH-1:0] i_write_data,
   input  logic                        i_write_en,
   input  logic                        i_clear,
   output logic                        o_ready
);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_e;

   localparam logic [4:0] IDX_FIRST = 5'd1;
   localparam logic [4:0] IDX_LAST  = 5'd31;

   state_e                      state_q, state_d;
   logic [4:0]                  idx_q, idx_d;
   logic                        wr_en;
   logic [4:0]                  wr_addr;
   logic [OPTION_REG_WIDTH-1:0] wr_data;
   logic [OPTION_REG_WIDTH-1:0] regs_q [0:OPTION_REG_COUNT-1];
   logic [OPTION_REG_WIDTH-1:0] rd_a, rd_b;

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         state_q <= ST_CLEAR;
         idx_q   <= IDX_FIRST;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
      end
   end

   // The sweep and user writes share a single write port, so storage stays RAM-inferable.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      wr_en   = 1'b0;
      wr_addr = idx_q;
      wr_data = '0;
      case (state_q)
         ST_CLEAR: begin
            wr_en   = 1'b1;
            wr_addr = idx_q;
            if (i_clear) begin
               idx_d = IDX_FIRST;
            end else if (idx_q == IDX_LAST) begin
               state_d = ST_READY;
            end else begin
               idx_d = idx_q + 5'd1;
            end
         end
         ST_READY: begin
            if (i_clear) begin
               state_d = ST_CLEAR;
               idx_d   = IDX_FIRST;
            end else if (i_write_en && (i_write_reg != 5'd0)) begin
               wr_en   = 1'b1;
               wr_addr = i_write_reg;
               wr_data = i_write_data;
            end
         end
         default: begin
            state_d = ST_CLEAR;
            idx_d   = IDX_FIRST;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (wr_en) begin
         regs_q[wr_addr] <= wr_data;
      end
   end

`ifdef REGFILE_BYPASS_EN
   logic fwd_ok;

   // A write discarded by i_clear is not forwarded either.
   always_comb begin
      fwd_ok = (state_q == ST_READY) && i_write_en && !i_clear && (i_write_reg != 5'd0);
      rd_a   = regs_q[i_sela];
      rd_b   = regs_q[i_selb];
      if (fwd_ok && (i_write_reg == i_sela)) begin
         rd_a = i_write_data;
      end
      if (fwd_ok && (i_write_reg == i_selb)) begin
         rd_b = i_write_data;
      end
   end
`else
   always_comb begin
      rd_a = regs_q[i_sela];
      rd_b = regs_q[i_selb];
   end
`endif

   // Register 0 is never written; its reads are forced to zero, as are all reads outside READY.
   always_comb begin
      o_ina = '0;
      o_inb = '0;
      if ((state_q == ST_READY) && (i_sela != 5'd0)) begin
         o_ina = rd_a;
      end
      if ((state_q == ST_READY) && (i_selb != 5'd0)) begin
         o_inb = rd_b;
      end
   end

   assign o_ready = (state_q == ST_READY);

endmodule

// File: tb/tb_regfile_bank.sv
// Scoreboard bench for regfile_bank: expectations are queued as stimulus is driven and popped at sample time.
module tb_regfile_bank;

   localparam int W = 64;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [4:0]   sela = '0, selb = '0, wreg = '0;
   logic [W-1:0] wdata = '0;
   logic         wen = 1'b0, clr = 1'b0;
   logic [W-1:0] ina, inb;
   logic         ready;

   int           total = 0;
   int           bad = 0;
   string        tag_q[$];
   logic [W-1:0] exp_q[$];

   always #5 clk = ~clk;

   regfile_bank #(.OPTION_REG_WIDTH(W), .OPTION_REG_COUNT(32)) dut (
      .i_clk(clk), .i_rst(rst_n), .i_sela(sela), .i_selb(selb),
      .o_ina(ina), .o_inb(inb), .i_write_reg(wreg), .i_write_data(wdata),
      .i_write_en(wen), .i_clear(clr), .o_ready(ready)
   );

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic expect_v(input string tag, input logic [W-1:0] v);
      tag_q.push_back(tag);
      exp_q.push_back(v);
   endtask

   task automatic sb_check(input logic [W-1:0] got);
      string        t;
      logic [W-1:0] e;
      if (exp_q.size() == 0) begin
         chk("sb_underflow", W'(exp_q.size()), W'(1));
      end else begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         chk(t, got, e);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [4:0] r, input logic [W-1:0] d);
      wen = 1'b1; wreg = r; wdata = d;
      step();
      wen = 1'b0;
   endtask

   // Entered one edge before the first sweep edge; expects 31 not-ready cycles then ready.
   task automatic sweep(input string tag);
      for (int k = 0; k < 31; k++) begin
         expect_v({tag, "_busy"}, '0);
         expect_v({tag, "_rd0"}, '0);
         @(negedge clk);
         sb_check(W'(ready));
         sb_check(ina);
         step();
      end
      expect_v({tag, "_ready"}, W'(1));
      @(negedge clk);
      sb_check(W'(ready));
   endtask

   task automatic read_a(input string tag, input logic [4:0] s, input logic [W-1:0] v);
      sela = s;
      expect_v(tag, v);
      @(negedge clk);
      sb_check(ina);
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      sela = 5'd5;
      #12;
      expect_v("rst_ready", '0);
      expect_v("rst_rd", '0);
      sb_check(W'(ready));
      sb_check(ina);
      @(posedge clk); #1;
      rst_n = 1'b1;
      sweep("init");
      step();

      for (int i = 0; i < 32; i++) begin
         sela = 5'(i);
         selb = 5'(31 - i);
         expect_v("init_a", '0);
         expect_v("init_b", '0);
         @(negedge clk);
         sb_check(ina);
         sb_check(inb);
         step();
      end

      wr(5'd5, 64'hDEADBEEF_00000001);
      sela = 5'd5; selb = 5'd5;
      expect_v("r5_a", 64'hDEADBEEF_00000001);
      expect_v("r5_b", 64'hDEADBEEF_00000001);
      @(negedge clk);
      sb_check(ina);
      sb_check(inb);
      step();

      wr(5'd0, '1);
      read_a("r0_zero", 5'd0, '0);

      wr(5'd7, 64'hAAAA);
      wen = 1'b1; wreg = 5'd7; wdata = 64'h1234; sela = 5'd7;
`ifdef REGFILE_BYPASS_EN
      expect_v("r7_same", 64'h1234);
`else
      expect_v("r7_same", 64'hAAAA);
`endif
      @(negedge clk);
      sb_check(ina);
      step();
      wen = 1'b0;
      read_a("r7_next", 5'd7, 64'h1234);

      wr(5'd3, 64'h55);
      read_a("r3_pre", 5'd3, 64'h55);
      clr = 1'b1; wen = 1'b1; wreg = 5'd3; wdata = 64'hFF;
      expect_v("clr_still_ready", W'(1));
      @(negedge clk);
      sb_check(W'(ready));
      step();
      clr = 1'b0;
      // Held write during the whole sweep must be ignored.
      wreg = 5'd2; wdata = 64'h77; sela = 5'd5;
      sweep("clr");
      wen = 1'b0;
      step();
      read_a("r3_cleared", 5'd3, '0);
      read_a("r2_ignored", 5'd2, '0);
      read_a("r5_cleared", 5'd5, '0);

      clr = 1'b1;
      step();
      clr = 1'b0;
      for (int k = 0; k < 15; k++) step();
      clr = 1'b1;
      step();
      clr = 1'b0;
      sweep("restart");
      step();

      wr(5'd20, 64'hBEEF);
      read_a("r20_pre", 5'd20, 64'hBEEF);
      clr = 1'b1;
      step();
      clr = 1'b0;
      for (int k = 0; k < 9; k++) step();
      rst_n = 1'b0;
      #1;
      expect_v("rstmid_ready", '0);
      expect_v("rstmid_rd", '0);
      sb_check(W'(ready));
      sb_check(ina);
      @(posedge clk); #1;
      rst_n = 1'b1;
      sweep("rstmid");
      step();
      read_a("r20_cleared", 5'd20, '0);

      wr(5'd9, 64'h99);
      read_a("r9_pre", 5'd9, 64'h99);
      #2;
      rst_n = 1'b0;
      #1;
      expect_v("rstrdy_ready", '0);
      expect_v("rstrdy_rd", '0);
      sb_check(W'(ready));
      sb_check(ina);
      @(posedge clk); #1;
      rst_n = 1'b1;
      sweep("rstrdy");
      step();
      read_a("r9_cleared", 5'd9, '0);

      chk("sb_drain", W'(exp_q.size()), '0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
